md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle multiply/divide controller beside the EX-stage ALU; owns the HI/LO registers.
//  Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and services MTHI/MTLO/MFHI/MFLO.
//  Raises StallMD to the hazard logic only when an MD op reaches EX while the unit is busy.
//  Non-MD instructions keep flowing during an iteration. Operands arrive already forwarded.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO are WIDTH each
//  CNT_W   6   iteration counter width (>= clog2(WIDTH)+1)
// PORTS
//  Clock      in   1   pipeline clock, rising edge
//  Reset_n    in   1   synchronous, active-low reset
//  MDStartE   in   1   MD-class instruction valid in EX this cycle
//  MDOpE      in   3   000 MULT,001 MULTU,010 DIV,011 DIVU,100 MTHI,101 MTLO,110 MFHI,111 MFLO
//  FlushE     in   1   EX instruction squashed; MD op in EX is ignored
//  SrcAE      in   32  forwarded rs operand (multiplicand/dividend/MT source)
//  SrcBE      in   32  forwarded rt operand (multiplier/divisor)
//  StallMD    out  1   freeze IF/ID/EX (PC, IFID, IDEX hold)
//  BusyMD     out  1   iteration in progress (state != IDLE)
//  MDResultE  out  32  HI (MFHI) or LO (MFLO), combinational; 0 otherwise
//  DivZero    out  1   1-cycle pulse in FIX state of a DIV/DIVU with SrcBE==0
//  HiOut      out  32  HI register (debug/trace)
//  LoOut      out  32  LO register (debug/trace)
// BEHAVIOUR
//  Reset (Reset_n==0 at edge, any state): state=IDLE, HI=LO=0, counter=0, DivZero=0.
//   Every output is low/zero the next cycle.
//  Accept = MDStartE & ~FlushE & ~StallMD.
//  StallMD = MDStartE & ~FlushE & BusyMD. An MD op arriving in the FIX cycle also stalls.
//  FSM IDLE -> MUL | DIV -> FIX -> IDLE.
//   IDLE: Accept with MULT*/DIV* latches the operands. Signed ops latch |SrcAE|, |SrcBE| and the signs.
//    The FSM enters MUL/DIV with counter=0.
//   MUL: shift-add on a 64-bit {acc,mplr}; one bit per cycle; after WIDTH cycles -> FIX.
//   DIV: restoring shift-subtract on a 64-bit {rem,quo}; WIDTH cycles -> FIX.
//   FIX: apply signs and write HI/LO; -> IDLE.
//  Latency: accept at cycle T. BusyMD is high T+1..T+WIDTH+1. HI/LO are updated at the end of T+WIDTH+1.
//   An MFHI/MFLO in EX at T+WIDTH+2 reads the new value.
//  Signed MULT: the 64-bit product is negated iff sign(A)^sign(B).
//  Signed DIV: quotient sign = sA^sB; remainder sign = sA.
//  Special DIV results:
//   0x80000000 / -1 gives LO=0x80000000, HI=0 (natural result of the abs algorithm, no trap).
//   Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=dividend (signed original).
//    Full latency still applies; DivZero pulses in FIX.
//  MTHI/MTLO: on Accept in IDLE, HI/LO <= SrcAE at that edge; no busy phase.
//  MFHI/MFLO: on Accept, MDResultE = HI/LO the same cycle. While stalled, MDResultE=0.
//  FlushE only gates acceptance. An in-flight iteration belongs to an older instruction and always completes.
//  Priority at an edge: Reset_n > FIX write > MT write. An MT write cannot coincide with FIX because StallMD covers it.
// STRUCTURE
//  Shared header md_defs.vh:
//   MD op encodings (MDOP_MULT..MDOP_MFLO), state encodings (S_IDLE,S_MUL,S_DIV,S_FIX), WIDTH default.
//  Sub-module md_iter_datapath: the 64-bit shift register plus adder/subtractor, one step per enable.
//   Its mode input (mul/div) comes from the FSM.
//  The FSM, counter, sign latches, HI/LO and stall logic stay in md_sequencer.
// TESTING
//  Reset: MULT accepted, Reset_n=0 at T+10 -> BusyMD=0, HiOut=LoOut=0 at T+11; no later HI/LO write.
//  MULT A=0xFFFFFFFE, B=3 at T, MFLO issued T+1 -> StallMD=1 T+1..T+33.
//   At T+34: MDResultE=0xFFFFFFFA, HI=0xFFFFFFFF.
//  MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 33 busy cycles.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  DIVU 5/0 -> DivZero=1 only at T+33; LO=0xFFFFFFFF, HI=5.
//  Idle ops: MTHI 0x1234 at T, MFHI at T+1 -> MDResultE=0x1234, StallMD=0.
//   MULT with FlushE=1 -> BusyMD stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package md_sequencer_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [2:0] {
      MDOP_MULT  = 3'b000,
      MDOP_MULTU = 3'b001,
      MDOP_DIV   = 3'b010,
      MDOP_DIVU  = 3'b011,
      MDOP_MTHI  = 3'b100,
      MDOP_MTLO  = 3'b101,
      MDOP_MFHI  = 3'b110,
      MDOP_MFLO  = 3'b111
   } md_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } md_state_t;

   // Only MULT and DIV interpret their operands as two's complement.
   function automatic logic op_is_signed(input md_op_t op);
      return (op == MDOP_MULT) || (op == MDOP_DIV);
   endfunction

endpackage

// File: rtl/md_iter_datapath.sv
// Iterative datapath: 2*WIDTH shift register {hi,lo} plus one adder/subtractor, one bit per step.
// Latency: WIDTH steps after load for a full product or quotient/remainder.
// Backpressure: none; advances only when step is high, load has priority.
// Ports: clk/rst_n (sync active-low), load (capture op_a/op_b), step (advance one bit),
//        mode_div (1 = restoring divide, 0 = shift-add multiply), op_a/op_b (unsigned magnitudes),
//        hi/lo (mul: product high/low; div: remainder/quotient).
module md_iter_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             mode_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] opb_q;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   always_comb begin
      // Multiply: add multiplicand when the current multiplier bit is set; the carry
      // becomes the new top bit after the right shift.
      mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opb_q}) : {1'b0, hi_q};
      // Divide: the shifted remainder needs WIDTH+1 bits because it may exceed 2^WIDTH-1.
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb_q});
      // When div_ge holds the true difference is below the divisor (or equals the
      // shifted value for a zero divisor), so WIDTH bits are enough.
      div_diff  = div_shift[WIDTH-1:0] - opb_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         opb_q <= '0;
      end else if (load) begin
         hi_q  <= '0;
         lo_q  <= op_a;
         opb_q <= op_b;
      end else if (step) begin
         if (mode_div) begin
            hi_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], div_ge};
         end else begin
            {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide controller beside the EX ALU; owns HI/LO and runs MULT/DIV one bit per cycle.
// Latency: MULT/DIV busy WIDTH+1 cycles after accept, HI/LO written at end of FIX; MT/MF single cycle.
// Backpressure: StallMD holds an unflushed MD op in EX while busy; non-MD instructions flow freely.
// Ports: Clock, Reset_n (sync active-low); MDStartE/MDOpE/FlushE/SrcAE/SrcBE from EX;
//        StallMD to hazard unit; BusyMD, DivZero status; MDResultE for MFHI/MFLO; HiOut/LoOut trace.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             MDStartE,
   input  logic [2:0]       MDOpE,
   input  logic             FlushE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   output logic             StallMD,
   output logic             BusyMD,
   output logic [WIDTH-1:0] MDResultE,
   output logic             DivZero,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut
);

   md_state_t        state;
   md_state_t        state_nxt;
   md_op_t           op;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             op_div_q;
   logic             sign_a;
   logic             sign_b;
   logic             div_zero_q;

   logic             accept;
   logic             start_mul;
   logic             start_div;
   logic             signed_op;
   logic             last_step;
   logic             dp_load;
   logic             dp_step;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] dp_hi;
   logic [WIDTH-1:0] dp_lo;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;

   assign op        = md_op_t'(MDOpE);
   assign accept    = MDStartE & ~FlushE & ~StallMD;
   assign start_mul = accept & ((op == MDOP_MULT) | (op == MDOP_MULTU));
   assign start_div = accept & ((op == MDOP_DIV) | (op == MDOP_DIVU));
   assign signed_op = op_is_signed(op);
   assign abs_a     = (signed_op & SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
   assign abs_b     = (signed_op & SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // FSM next state and control outputs.
   always_comb begin
      state_nxt = state;
      BusyMD    = (state != S_IDLE);
      StallMD   = MDStartE & ~FlushE & (state != S_IDLE);
      dp_load   = 1'b0;
      dp_step   = 1'b0;
      DivZero   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_mul) begin
               dp_load   = 1'b1;
               state_nxt = S_MUL;
            end else if (start_div) begin
               dp_load   = 1'b1;
               state_nxt = S_DIV;
            end
         end
         S_MUL, S_DIV: begin
            dp_step = 1'b1;
            if (last_step) begin
               state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            DivZero   = op_div_q & div_zero_q;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sign fix-up of the unsigned magnitudes. A zero divisor leaves the dividend
   // magnitude in the remainder, so HI = dividend falls out of the remainder sign rule;
   // only LO needs forcing.
   always_comb begin
      fix_hi = dp_hi;
      fix_lo = dp_lo;
      if (!op_div_q) begin
         if (sign_a ^ sign_b) begin
            {fix_hi, fix_lo} = -{dp_hi, dp_lo};
         end
      end else begin
         fix_lo = (sign_a ^ sign_b) ? -dp_lo : dp_lo;
         fix_hi = sign_a ? -dp_hi : dp_hi;
         if (div_zero_q) begin
            fix_lo = '1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         cnt        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         op_div_q   <= 1'b0;
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         if (dp_load) begin
            cnt        <= '0;
            op_div_q   <= start_div;
            sign_a     <= signed_op & SrcAE[WIDTH-1];
            sign_b     <= signed_op & SrcBE[WIDTH-1];
            div_zero_q <= (SrcBE == '0);
         end else if (dp_step) begin
            cnt <= cnt + 1'b1;
         end
         // An MT op can never be accepted during FIX because StallMD covers that cycle.
         if (state == S_FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end else if (accept && (op == MDOP_MTHI)) begin
            hi_q <= SrcAE;
         end else if (accept && (op == MDOP_MTLO)) begin
            lo_q <= SrcAE;
         end
      end
   end

   always_comb begin
      MDResultE = '0;
      if (accept && (op == MDOP_MFHI)) begin
         MDResultE = hi_q;
      end else if (accept && (op == MDOP_MFLO)) begin
         MDResultE = lo_q;
      end
   end

   assign HiOut = hi_q;
   assign LoOut = lo_q;

   md_iter_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk      (Clock),
      .rst_n    (Reset_n),
      .load     (dp_load),
      .step     (dp_step),
      .mode_div (state == S_DIV),
      .op_a     (abs_a),
      .op_b     (abs_b),
      .hi       (dp_hi),
      .lo       (dp_lo)
   );

endmodule

// File: tb/tb_md_sequencer.sv
// Testbench for md_sequencer: directed corner cases plus random op streams.
// Expected HI/LO come from an in-order architectural model using native 64-bit arithmetic.
// A negedge monitor checks MF results, busy windows, DivZero pulses and HI/LO writes.
module tb_md_sequencer;

   localparam int W        = 32;
   localparam int BUSY_LEN = W + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          md_start;
   logic [2:0]    md_op;
   logic          flush;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic          stall_md;
   logic          busy_md;
   logic [W-1:0]  md_result;
   logic          div_zero;
   logic [W-1:0]  hi_out;
   logic [W-1:0]  lo_out;

   always #5 clk = ~clk;

   md_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .Clock     (clk),
      .Reset_n   (rst_n),
      .MDStartE  (md_start),
      .MDOpE     (md_op),
      .FlushE    (flush),
      .SrcAE     (src_a),
      .SrcBE     (src_b),
      .StallMD   (stall_md),
      .BusyMD    (busy_md),
      .MDResultE (md_result),
      .DivZero   (div_zero),
      .HiOut     (hi_out),
      .LoOut     (lo_out)
   );

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      bit           dz;
   } res_t;

   res_t         res_q[$];   // expected outcome of each accepted MULT/DIV
   logic [W-1:0] exp_q[$];   // expected MDResultE of each accepted MFHI/MFLO
   int           acc_q[$];   // cycle numbers at which MULT/DIV were accepted

   logic [W-1:0] ref_hi;
   logic [W-1:0] ref_lo;
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s @cyc %0d: event without matching expectation or timeout", name, cyc);
   endtask

   // Architectural result of one MULT/MULTU/DIV/DIVU.
   task automatic model_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] hi, output logic [W-1:0] lo);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = '0;
      lo = '0;
      case (op)
         3'd0: begin
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
         end
         3'd1: begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         3'd2: begin
            if (b == 0) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else begin
               q  = sa / sb;
               r  = sa % sb;
               hi = r[31:0];
               lo = q[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else begin
               hi = a % b;
               lo = a / b;
            end
         end
      endcase
   endtask

   // Present one MD instruction in EX starting just after a rising edge, hold it while
   // stalled, and return just after the edge that takes it (or retires it if flushed).
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit fl, output int stalls);
      logic [W-1:0] h;
      logic [W-1:0] l;
      res_t         r;
      md_start = 1'b1;
      md_op    = op;
      src_a    = a;
      src_b    = b;
      flush    = fl;
      if (!fl) begin
         case (op)
            3'd4: ref_hi = a;
            3'd5: ref_lo = a;
            3'd6: exp_q.push_back(ref_hi);
            3'd7: exp_q.push_back(ref_lo);
            default: begin
               model_md(op, a, b, h, l);
               r.hi = h;
               r.lo = l;
               r.dz = op[1] && (b == 0);
               res_q.push_back(r);
               ref_hi = h;
               ref_lo = l;
            end
         endcase
      end
      stalls = 0;
      @(negedge clk);
      while (stall_md && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 200) begin
         fail_now("stall_timeout");
      end
      @(posedge clk);
      #1;
      md_start = 1'b0;
      flush    = 1'b0;
      md_op    = 3'd0;
      src_a    = '0;
      src_b    = '0;
   endtask

   task automatic idle(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Monitor: everything sampled on the falling edge.
   int   run_len = 0;
   int   dz_cnt  = 0;
   int   dz_pos  = 0;
   bit   m_acc;
   res_t m_res;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         run_len = 0;
         dz_cnt  = 0;
         dz_pos  = 0;
         res_q.delete();
         exp_q.delete();
         acc_q.delete();
      end else begin
         m_acc = md_start && !flush && !stall_md;
         if (m_acc && (md_op[2:1] == 2'b11)) begin
            if (exp_q.size() == 0) fail_now("mf_unexpected");
            else chk("mf_result", md_result, exp_q.pop_front());
         end else begin
            chk("result_zero", md_result, 0);
         end

         if (busy_md) begin
            if (run_len == 0) begin
               if (acc_q.size() == 0) fail_now("busy_unexpected");
               else chk("busy_start", cyc, acc_q.pop_front() + 1);
            end
            run_len++;
            if (div_zero) begin
               dz_cnt++;
               dz_pos = run_len;
            end
         end else begin
            chk("divzero_idle", div_zero, 0);
            if (run_len > 0) begin
               if (res_q.size() == 0) begin
                  fail_now("result_unexpected");
               end else begin
                  m_res = res_q.pop_front();
                  chk("busy_len", run_len, BUSY_LEN);
                  chk("divzero_cnt", dz_cnt, m_res.dz ? 1 : 0);
                  chk("divzero_pos", dz_pos, m_res.dz ? BUSY_LEN : 0);
                  chk("hi_write", hi_out, m_res.hi);
                  chk("lo_write", lo_out, m_res.lo);
               end
               run_len = 0;
               dz_cnt  = 0;
               dz_pos  = 0;
            end
         end

         if (m_acc && !md_op[2]) acc_q.push_back(cyc);
      end
   end

   initial begin
      int           s;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           fl;

      rst_n    = 1'b0;
      md_start = 1'b0;
      md_op    = 3'd0;
      flush    = 1'b0;
      src_a    = '0;
      src_b    = '0;
      ref_hi   = '0;
      ref_lo   = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", stall_md, 0);
      chk("rst_busy", busy_md, 0);
      chk("rst_result", md_result, 0);
      chk("rst_divzero", div_zero, 0);
      chk("rst_hi", hi_out, 0);
      chk("rst_lo", lo_out, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Reset in the middle of a MULT clears HI/LO and the iteration.
      issue(3'd4, 32'hAAAA_0001, 32'h0, 1'b0, s);
      issue(3'd5, 32'h5555_0002, 32'h0, 1'b0, s);
      issue(3'd0, 32'h0123_4567, 32'h0000_0089, 1'b0, s);   // now in cycle T+1
      repeat (9) @(posedge clk);
      #1;                                                  // cycle T+10
      rst_n = 1'b0;
      @(posedge clk);
      #1;                                                  // cycle T+11
      chk("midrst_busy", busy_md, 0);
      chk("midrst_hi", hi_out, 0);
      chk("midrst_lo", lo_out, 0);
      rst_n  = 1'b1;
      ref_hi = '0;
      ref_lo = '0;
      idle(40);
      chk("midrst_hi_later", hi_out, 0);
      chk("midrst_lo_later", lo_out, 0);
      chk("midrst_busy_later", busy_md, 0);

      // MULT -2 * 3 with MFLO right behind it: stalled for the whole busy window.
      issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, s);
      issue(3'd7, 32'h0, 32'h0, 1'b0, s);
      chk("mflo_stall_cycles", s, BUSY_LEN);
      issue(3'd6, 32'h0, 32'h0, 1'b0, s);
      chk("mfhi_nostall", s, 0);

      // MULTU max * max, DIV -7/2, DIV min/-1, DIVU 5/0.
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, s);
      issue(3'd6, 32'h0, 32'h0, 1'b0, s);
      issue(3'd7, 32'h0, 32'h0, 1'b0, s);
      issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, s);
      issue(3'd7, 32'h0, 32'h0, 1'b0, s);
      issue(3'd6, 32'h0, 32'h0, 1'b0, s);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, s);
      issue(3'd7, 32'h0, 32'h0, 1'b0, s);
      issue(3'd6, 32'h0, 32'h0, 1'b0, s);
      issue(3'd3, 32'h0000_0005, 32'h0000_0000, 1'b0, s);
      issue(3'd7, 32'h0, 32'h0, 1'b0, s);
      issue(3'd6, 32'h0, 32'h0, 1'b0, s);
      issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, s);  // signed divide by zero
      idle(40);

      // Idle MTHI then MFHI: no stall, value forwarded through HI.
      issue(3'd4, 32'h0000_1234, 32'h0, 1'b0, s);
      issue(3'd6, 32'h0, 32'h0, 1'b0, s);
      chk("mt_mf_nostall", s, 0);

      // Flushed MULT is never started.
      issue(3'd0, 32'h0000_0007, 32'h0000_0009, 1'b1, s);
      chk("flush_busy", busy_md, 0);
      chk("flush_hi", hi_out, ref_hi);
      chk("flush_lo", lo_out, ref_lo);
      idle(3);

      // Random op stream with random gaps (MF/MT/flushes land mid-iteration too).
      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         fl = ($urandom_range(0, 7) == 0);
         issue(op, a, b, fl, s);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 40));
      end
      issue(3'd6, 32'h0, 32'h0, 1'b0, s);
      issue(3'd7, 32'h0, 32'h0, 1'b0, s);

      idle(40);
      chk("pending_results", res_q.size(), 0);
      chk("pending_mf", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
